array_ram: RTL and testbench
============================

# array_ram

Single-port synchronous word memory serving as the backing store for `Array` interfaces of compiled dataflow blocks. A requester drives `addr`/`we`/`di` with `valid`; the block performs one read or write per accepted request and returns a one-cycle `ready` strobe with the read (or written) word on `do`. On reset it sweeps the whole memory to zero before accepting requests.

## Interface
- `N`, default `intN` (8): data word width.
- `A`, default `addrN` (8): address width; depth is 2^A words.
- `clk`  in  1  clock; all logic on rising edge.
- `nrst`  in  1  reset: synchronous, active-low.
- `addr`  in  A  word address.
- `we`  in  1  1 = write `di` to `addr`, 0 = read `addr`.
- `di`  in  N  write data.
- `valid`  in  1  request present.
- `do`  out  N  response data (registered).
- `ready`  out  1  response strobe, high for exactly the cycle after an accepted request.

## Operation
- Two states: CLEAR and IDLE.
- Reset (`nrst`=0 at a rising edge): state←CLEAR, clear counter←0, `ready`←0, `do`←0.
- CLEAR: each cycle write 0 to `mem[counter]` and increment the counter; after writing address 2^A−1, move to IDLE. Requests are not accepted in CLEAR (no memory access from the port, no `ready`).
- IDLE: a request is accepted on every rising edge with `valid`=1.
  - `we`=1: `mem[addr]`←`di`; `do`←`di`.
  - `we`=0: `do`←`mem[addr]` (value before this edge).
- `ready`←1 if a request was accepted this edge, else 0. `do` holds its last value when no request is accepted.
- The requester keeps `valid` (and the request fields) steady until it samples `ready`=1. While `valid` stays high, repeated accesses are idempotent: a re-read returns the same word, and a re-write stores the same data.
- Address arithmetic is plain unsigned with no wrap logic needed; every A-bit address is in range.
- `di` is ignored on reads. `we` is ignored when `valid`=0.

## Timing
- Read and write latency: 1 cycle. A request accepted at edge k gives `ready`=1 and valid `do` during cycle k..k+1.
- Throughput: one request per cycle in IDLE.
- Read-after-write to the same address in the next cycle returns the new data, because the write completes at the accepting edge.
- Clear takes 2^A cycles after the reset edge. The first request is accepted at the edge 2^A+1 cycles after the last reset edge (default 257).
- Reset in the middle of operation, including in the middle of a clear: the clear restarts from address 0 and `ready` is 0 from the next edge. A pending request is dropped.
- `nrst`=0 has priority over any request on the same edge.

## Structure
- The shared primitives header provides `intN`, `addrN`, `intT`, `addrT`, `true` and `false`. The block uses them and defines no constants of its own.
- Sub-module: `array_ram_core`, a plain inferred single-port RAM with write enable and a registered read, behind the CLEAR/IDLE controller. Splitting it out is optional.

## Test plan
- Reset for 2 cycles, then hold a read of addr 3 with `valid`=1 → no `ready` during the 256-cycle clear; then `ready`=1 for one cycle with `do`=0.
- After clear, write addr 3 = 42 → next cycle `ready`=1 and `do`=42. Then read addr 3 → `do`=42. Read addr 4 → `do`=0.
- Read-modify-write: read addr 3 (42), write addr 3 = 42+42 = 84 on the cycle after `ready`, then read addr 3 → 84. This is the add-at pattern: `res` = 84.
- Boundaries: write addr 255 = 7 and addr 0 = 9, then read both → 7 and 9. `valid`=0 with `we`=1, addr 0, `di`=5 → no write and `ready` stays 0; addr 0 still reads 9.
- Back-to-back: write addr 10 = 1 followed immediately by read addr 10 → the read returns 1, with `ready` high for 2 consecutive cycles.
- Reset mid-clear (cycle 100) and again after data has been written → the clear restarts, `ready` stays 0 for 256 cycles, and every address read afterwards returns 0.

Source files
------------

// File: rtl/array_ram_pkg.sv
// Shared primitives for compiled dataflow blocks: default word/address widths,
// their types, boolean constants and the array_ram controller state type.
package array_ram_pkg;

    localparam int intN  = 8;
    localparam int addrN = 8;

    typedef logic [intN-1:0]  intT;
    typedef logic [addrN-1:0] addrT;

    localparam logic true  = 1'b1;
    localparam logic false = 1'b0;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } array_ram_state_e;

endpackage

// File: rtl/array_ram_core.sv
// Inferred single-port RAM with write enable and a registered output that
// returns the written word on writes and the stored word on reads.
module array_ram_core
    import array_ram_pkg::*;
#(
    parameter int N = intN,
    parameter int A = addrN
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         we,
    input  logic [A-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata
);

    logic [N-1:0] mem [0:(1<<A)-1];
    logic [N-1:0] rdata_d;
    logic [N-1:0] rdata_q;

    // Output holds its value on cycles without an access.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? wdata : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/array_ram.sv
// Backing store for Array interfaces: zero-sweeps the memory after reset, then
// serves one read or write per valid cycle with a one-cycle ready strobe.
module array_ram
    import array_ram_pkg::*;
#(
    parameter int N = intN,
    parameter int A = addrN
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [A-1:0] addr,
    input  logic         we,
    input  logic [N-1:0] di,
    input  logic         valid,
    // 'do' is a reserved word, so the response port is dout.
    output logic [N-1:0] dout,
    output logic         ready
);

    array_ram_state_e state_q, state_d;
    logic [A-1:0]     cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic             mem_en;
    logic             mem_we;
    logic [A-1:0]     mem_addr;
    logic [N-1:0]     mem_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = false;
        mem_en    = false;
        mem_we    = false;
        mem_addr  = addr;
        mem_wdata = di;

        case (state_q)
            CLEAR: begin
                mem_en    = true;
                mem_we    = true;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (valid) begin
                    mem_en  = true;
                    mem_we  = we;
                    ready_d = true;
                end
            end
            default: state_d = CLEAR;
        endcase

        // Reset wins over any request or clear write on the same edge.
        if (!nrst) begin
            mem_en = false;
            mem_we = false;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= false;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    array_ram_core #(
        .N(N),
        .A(A)
    ) u_core (
        .clk  (clk),
        .nrst (nrst),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(dout)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_array_ram.sv
// Self-checking bench for array_ram: directed scenarios plus random traffic,
// compared every cycle against a memory-array model of the request rules.
module tb_array_ram;

    localparam int N     = 8;
    localparam int A     = 8;
    localparam int DEPTH = 1 << A;

    logic         clk   = 1'b0;
    logic         nrst  = 1'b0;
    logic         we    = 1'b0;
    logic         valid = 1'b0;
    logic [A-1:0] addr  = '0;
    logic [N-1:0] di    = '0;
    logic [N-1:0] dout;
    logic         ready;

    int total = 0;
    int bad   = 0;

    array_ram #(.N(N), .A(A)) dut (
        .clk  (clk),
        .nrst (nrst),
        .addr (addr),
        .we   (we),
        .di   (di),
        .valid(valid),
        .dout (dout),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // Model: reset makes the whole memory read as zero and blocks requests for
    // DEPTH cycles; afterwards each valid cycle is one access answered next cycle.
    logic [N-1:0] m_mem [DEPTH];
    int           m_clear_left = 0;
    logic         m_known = 1'b0;
    logic         m_ready = 1'b0;
    logic [N-1:0] m_do    = '0;

    always @(posedge clk) begin
        if (!nrst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_clear_left = DEPTH;
            m_ready      = 1'b0;
            m_do         = '0;
            m_known      = 1'b1;
        end else if (m_clear_left > 0) begin
            m_clear_left = m_clear_left - 1;
            m_ready      = 1'b0;
        end else if (valid) begin
            m_ready = 1'b1;
            if (we) begin
                m_mem[addr] = di;
                m_do        = di;
            end else begin
                m_do = m_mem[addr];
            end
        end else begin
            m_ready = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            check("mon_ready", {31'd0, ready}, {31'd0, m_ready});
            check("mon_do", {24'd0, dout}, {24'd0, m_do});
        end
    end

    // Called at a negedge; holds the request until ready is seen at a negedge.
    task automatic req(input logic w, input logic [A-1:0] a, input logic [N-1:0] d,
                       output logic [N-1:0] r, output int lat);
        valid = 1'b1;
        we    = w;
        addr  = a;
        di    = d;
        lat   = 1;
        @(negedge clk);
        while (!ready && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready", {31'd0, ready}, 32'd1);
        r = dout;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        nrst = 1'b0;
        repeat (n) @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        int lat;

        // Reset for 2 cycles with a read of addr 3 already held.
        valid = 1'b1; we = 1'b0; addr = 8'd3; di = '0;
        do_reset(2);
        req(1'b0, 8'd3, 8'd0, r, lat);
        check("clear_latency", lat, 257);
        check("first_read", {24'd0, r}, 32'd0);

        req(1'b1, 8'd3, 8'd42, r, lat);
        check("write3_do", {24'd0, r}, 32'd42);
        check("write3_lat", lat, 1);
        req(1'b0, 8'd3, 8'd0, r, lat);
        check("read3", {24'd0, r}, 32'd42);
        req(1'b0, 8'd4, 8'd0, r, lat);
        check("read4", {24'd0, r}, 32'd0);

        // Read-modify-write: add-at.
        req(1'b0, 8'd3, 8'd0, r, lat);
        req(1'b1, 8'd3, r + r, r, lat);
        req(1'b0, 8'd3, 8'd0, r, lat);
        check("add_at", {24'd0, r}, 32'd84);

        req(1'b1, 8'd255, 8'd7, r, lat);
        req(1'b1, 8'd0, 8'd9, r, lat);
        req(1'b0, 8'd255, 8'd0, r, lat);
        check("read255", {24'd0, r}, 32'd7);
        req(1'b0, 8'd0, 8'd0, r, lat);
        check("read0", {24'd0, r}, 32'd9);

        valid = 1'b0; we = 1'b1; addr = 8'd0; di = 8'd5;
        repeat (3) begin
            @(negedge clk);
            check("novalid_ready", {31'd0, ready}, 32'd0);
        end
        req(1'b0, 8'd0, 8'd0, r, lat);
        check("read0_after_novalid", {24'd0, r}, 32'd9);

        // Back-to-back write then read of the same address.
        req(1'b1, 8'd10, 8'd1, r, lat);
        req(1'b0, 8'd10, 8'd0, r, lat);
        check("b2b_read", {24'd0, r}, 32'd1);
        check("b2b_lat", lat, 1);

        // Random traffic with gaps; a narrow address window forces reuse.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                we = 1'($urandom);
                di = N'($urandom);
                addr = A'($urandom);
                idle($urandom_range(1, 2));
            end else begin
                req(1'($urandom),
                    ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 15)),
                    N'($urandom), r, lat);
            end
        end

        // Reset in the middle of a clear restarts it.
        idle(1);
        do_reset(1);
        repeat (100) @(negedge clk);
        do_reset(1);
        req(1'b0, 8'd3, 8'd0, r, lat);
        check("midclear_latency", lat, 257);
        check("midclear_read", {24'd0, r}, 32'd0);

        // Reset after data is written, with a write pending during reset.
        req(1'b1, 8'd20, 8'd55, r, lat);
        req(1'b1, 8'd200, 8'd66, r, lat);
        valid = 1'b1; we = 1'b1; addr = 8'd20; di = 8'd99;
        do_reset(2);
        req(1'b0, 8'd20, 8'd0, r, lat);
        check("rereset_latency", lat, 257);
        check("rereset_read20", {24'd0, r}, 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            req(1'b0, A'(a), N'($urandom), r, lat);
            check("post_reset_zero", {24'd0, r}, 32'd0);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
